// File: rtl/pp_gen_pipe_pkg.sv
// pp_gen_pipe_pkg: shared multiplier constants and partial-product helpers
package pp_gen_pipe_pkg;

    localparam int PP_WIDTH = 16;
    localparam int PP_MAX_W = 32;

    // Constant the downstream adder adds to a signed array: 2^w + 2^(2w-1)
    function automatic logic [63:0] bw_corr(input int w);
        return (64'd1 << w) + (64'd1 << (2 * w - 1));
    endfunction

    // Single term; in signed mode the last row and column flip, except their corner
    function automatic logic pp_term(input logic ai, input logic bj, input logic sgn,
                                     input int i, input int j, input int w);
        return (ai & bj) ^ (sgn & ((i == w - 1) != (j == w - 1)));
    endfunction

    // Whole array for a width up to PP_MAX_W, term [i][j] at bit i*w+j
    function automatic logic [PP_MAX_W*PP_MAX_W-1:0] pp_array(input logic [31:0] a,
                                                              input logic [31:0] b,
                                                              input logic sgn,
                                                              input int w);
        logic [PP_MAX_W*PP_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < PP_MAX_W; i++)
            for (int j = 0; j < PP_MAX_W; j++)
                if (i < w && j < w) r[i*w+j] = pp_term(a[i], b[j], sgn, i, j, w);
        return r;
    endfunction

endpackage

// File: rtl/pp_array_comb.sv
// pp_array_comb: combinational WIDTH x WIDTH partial-product array
//   a_i, b_i  operands; signed_i selects Baugh-Wooley terms
//   pp_o      array indexed [i][j], i = a-bit, j = b-bit
module pp_array_comb
    import pp_gen_pipe_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH
) (
    input  logic [WIDTH-1:0]            a_i,
    input  logic [WIDTH-1:0]            b_i,
    input  logic                        signed_i,
    output logic [WIDTH-1:0][WIDTH-1:0] pp_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        for (genvar j = 0; j < WIDTH; j++) begin : g_col
            assign pp_o[i][j] = pp_term(a_i[i], b_i[j], signed_i, i, j, WIDTH);
        end
    end

endmodule

// File: rtl/pp_gen_pipe.sv
// pp_gen_pipe: two-stage valid/ready pipeline producing a partial-product array
//   in_*   operand pair, mode and tag with valid/ready handshake
//   out_*  registered array, mode and tag with valid/ready handshake
module pp_gen_pipe
    import pp_gen_pipe_pkg::*;
#(
    parameter int WIDTH = PP_WIDTH,
    parameter int TAG_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    input  logic                        in_signed,
    input  logic [TAG_W-1:0]            in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0][WIDTH-1:0] out_pp,
    output logic                        out_signed,
    output logic [TAG_W-1:0]            out_tag
);

    logic                        s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic                        s1_ld, s2_ld;
    logic [WIDTH-1:0]            a_q, b_q;
    logic                        sg1_q, sg2_q;
    logic [TAG_W-1:0]            tag1_q, tag2_q;
    logic [WIDTH-1:0][WIDTH-1:0] pp_d, pp_q;

    // A stage may load when empty or when its contents leave this cycle
    always_comb begin
        s2_ld  = !s2_v_q || out_ready;
        s1_ld  = !s1_v_q || s2_ld;
        s1_v_d = s1_ld ? in_valid : s1_v_q;
        s2_v_d = s2_ld ? s1_v_q : s2_v_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_ld && in_valid) begin
            a_q    <= in_a;
            b_q    <= in_b;
            sg1_q  <= in_signed;
            tag1_q <= in_tag;
        end
        if (s2_ld && s1_v_q) begin
            pp_q   <= pp_d;
            sg2_q  <= sg1_q;
            tag2_q <= tag1_q;
        end
    end

    pp_array_comb #(.WIDTH(WIDTH)) u_arr (
        .a_i      (a_q),
        .b_i      (b_q),
        .signed_i (sg1_q),
        .pp_o     (pp_d)
    );

    assign in_ready   = s1_ld;
    assign out_valid  = s2_v_q;
    assign out_pp     = pp_q;
    assign out_signed = sg2_q;
    assign out_tag    = tag2_q;

endmodule

// File: tb/tb_pp_gen_pipe.sv
// tb_pp_gen_pipe: directed and random checks of pp_gen_pipe at widths 8, 16, 32
module tb_pp_gen_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  t;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, out_ready, in_signed;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag;
    logic        r8, r16, r32, v8, v16, v32, sg8, sg16, sg32;
    logic [3:0]  t8, t16, t32;
    logic [7:0][7:0]   p8;
    logic [15:0][15:0] p16;
    logic [31:0][31:0] p32;

    int    tests = 0, fails = 0, cyc_n = 0;
    beat_t q[$];
    int    ecyc[$];
    logic  stall_prev = 1'b0, held = 1'b0;
    logic [3:0]   prev_tag = '0, last_tag = '0;
    logic [255:0] prev_pp = '0, ex;

    pp_gen_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(v8), .out_ready(out_ready), .out_pp(p8), .out_signed(sg8), .out_tag(t8));
    pp_gen_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(v16), .out_ready(out_ready), .out_pp(p16), .out_signed(sg16), .out_tag(t16));
    pp_gen_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(v32), .out_ready(out_ready), .out_pp(p32), .out_signed(sg32), .out_tag(t32));

    task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int w);
        return (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Weighted sum of the array bits plus the signed correction, modulo 2^(2w)
    function automatic logic [63:0] arr_sum(input logic [1023:0] pp, input logic s, input int w);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (pp[i*w+j]) acc = acc + (64'd1 << (i + j));
        if (s) acc = acc + (64'd1 << w) + (64'd1 << (2 * w - 1));
        return acc & msk(w);
    endfunction

    function automatic logic [63:0] exp_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        logic [63:0] x, y, lo;
        lo = (64'd1 << w) - 64'd1;
        x = {32'd0, a} & lo;
        y = {32'd0, b} & lo;
        if (s && x[w-1]) x = x | ~lo;
        if (s && y[w-1]) y = y | ~lo;
        return (x * y) & msk(w);
    endfunction

    task automatic emit_chk(input string nm, input logic [1023:0] pp, input logic sg,
                            input logic [3:0] tg, input int w, input beat_t e);
        chk({nm, "_prod"}, 256'(arr_sum(pp, e.s, w)), 256'(exp_prod(e.a, e.b, e.s, w)));
        chk({nm, "_sgn"}, 256'(sg), 256'(e.s));
        chk({nm, "_tag"}, 256'(tg), 256'(e.t));
    endtask

    // Bookkeeping for the cycle whose inputs were just driven, then advance one clock
    task automatic cyc();
        beat_t e;
        #1;
        if (rst) begin
            q.delete();
            ecyc.delete();
            stall_prev = 1'b0;
            held = 1'b0;
        end else begin
            chk("ctl_match", 256'({v8, v32, r8, r32}), 256'({v16, v16, r16, r16}));
            if (stall_prev) begin
                chk("hold_valid", 256'(v16), 256'(1'b1));
                chk("hold_tag", 256'(t16), 256'(prev_tag));
                chk("hold_pp", 256'(p16), prev_pp);
            end
            if (v16 && out_ready) begin
                if (q.size() == 0) chk("emit_extra", 256'(q.size()), 256'(1));
                else begin
                    e = q.pop_front();
                    emit_chk("w8", 1024'(p8), sg8, t8, 8, e);
                    emit_chk("w16", 1024'(p16), sg16, t16, 16, e);
                    emit_chk("w32", p32, sg32, t32, 32, e);
                    ecyc.push_back(cyc_n);
                    last_tag = t16;
                end
            end
            if (in_valid && r16) q.push_back('{in_a, in_b, in_signed, in_tag});
            stall_prev = v16 && !out_ready;
            prev_tag = t16;
            prev_pp = p16;
            held = in_valid && !r16;
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [3:0] t);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_signed = s;
        in_tag = t;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        in_signed = 1'b0;
        in_tag = '0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_ov", 256'({v8, v16, v32}), 256'(3'b000));

        // unsigned all-ones times one
        out_ready = 1'b1;
        drive(32'h0000FFFF, 32'h1, 1'b0, 4'h5);
        #1 chk("rdy037", 256'(r16), 256'(1'b1));
        cyc();
        in_valid = 1'b0;
        chk("lat037", 256'(v16), 256'(1'b0));
        cyc();
        ex = '0;
        for (int i = 0; i < 16; i++) ex[i*16] = 1'b1;
        chk("ov037", 256'(v16), 256'(1'b1));
        chk("pp037", p16, ex);
        chk("tag037", 256'(t16), 256'(4'h5));
        cyc();

        // signed -1 times 1
        drive(32'h0000FFFF, 32'h1, 1'b1, 4'h6);
        cyc();
        in_valid = 1'b0;
        cyc();
        ex = '0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                ex[i*16+j] = (j == 0 && i < 15) || (j == 15 && i < 15) || (i == 15 && j > 0 && j < 15);
        chk("ov038", 256'(v16), 256'(1'b1));
        chk("sg038", 256'(sg16), 256'(1'b1));
        chk("pp038", p16, ex);
        chk("sum038", 256'(arr_sum(1024'(p16), 1'b1, 16)), 256'(64'hFFFFFFFF));
        cyc();

        // back-to-back, alternating mode
        ecyc.delete();
        for (int k = 0; k < 8; k++) begin
            drive($urandom, $urandom, k[0], 4'(k));
            cyc();
        end
        in_valid = 1'b0;
        for (int n = 0; n < 6; n++) cyc();
        chk("n039", 256'(ecyc.size()), 256'(8));
        chk("span039", 256'(ecyc.size() > 0 ? ecyc[$] - ecyc[0] : -1), 256'(7));

        // fill then stall for 5 cycles
        out_ready = 1'b0;
        drive($urandom, $urandom, 1'b0, 4'h1);
        #1 chk("rdy040a", 256'(r16), 256'(1'b1));
        cyc();
        drive($urandom, $urandom, 1'b1, 4'h2);
        #1 chk("rdy040b", 256'(r16), 256'(1'b1));
        cyc();
        drive($urandom, $urandom, 1'b1, 4'h3);
        for (int n = 0; n < 5; n++) begin
            #1 chk("rdy040_stall", 256'(r16), 256'(1'b0));
            cyc();
        end
        out_ready = 1'b1;
        #1 chk("rdy040_rel", 256'(r16), 256'(1'b1));
        chk("rel040a", 256'({v16, t16}), 256'({1'b1, 4'h1}));
        cyc();
        in_valid = 1'b0;
        chk("rel040b", 256'({v16, t16}), 256'({1'b1, 4'h2}));
        cyc();
        chk("rel040c", 256'({v16, t16}), 256'({1'b1, 4'h3}));
        cyc();
        cyc();

        // reset while both stages hold beats
        out_ready = 1'b0;
        drive($urandom, $urandom, 1'b0, 4'h6);
        cyc();
        drive($urandom, $urandom, 1'b1, 4'h7);
        cyc();
        chk("full041", 256'({v16, r16}), 256'({1'b1, 1'b0}));
        rst = 1'b1;
        out_ready = 1'b1;
        drive($urandom, $urandom, 1'b0, 4'h9);
        cyc();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst041", 256'(v16), 256'(1'b0));
        drive($urandom, $urandom, 1'b1, 4'hA);
        cyc();
        in_valid = 1'b0;
        for (int n = 0; n < 6; n++) cyc();
        chk("n041", 256'(ecyc.size()), 256'(1));
        chk("first041", 256'(last_tag), 256'(4'hA));

        // random valid/ready regression
        for (int n = 0; n < 600; n++) begin
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a = $urandom;
                in_b = $urandom;
                in_signed = 1'($urandom_range(0, 1));
                in_tag = 4'($urandom_range(0, 15));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (!held) in_valid = 1'b0;
            cyc();
        end
        chk("drain", 256'(q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
